// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port round-robin arbiter in front of a single memory port.
//            Port 0 (CPU) and port 1 (debug/DMA) compete. Each transaction
//            runs IDLE -> ACCESS -> DONE. A wait counter bounds how long the
//            memory may stall before the transaction is closed with err=1.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15   // legal range 1..255
) (
  input  logic          clk,
  input  logic          reset,
  // requester port 0 (CPU)
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  // requester port 1 (debug/DMA)
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  // status
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The wait counter is 8 bits wide, so TIMEOUT is compared in that width.
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t          state;
  state_t          state_next;
  logic [7:0]      wait_cnt;
  logic [7:0]      wait_cnt_next;
  logic            last_owner;

  logic            any_req;
  logic            winner;
  logic            grant_take;
  logic            owner_we;

  logic            capture;
  logic [DW-1:0]   capture_rdata;
  logic            capture_err;

  // Arbitration: a lone requester wins outright; on a tie the port that did
  // not win last time is chosen, which gives strict alternation under load.
  always_comb begin
    any_req = m0_req | m1_req;
    winner  = (m0_req & m1_req) ? ~last_owner : m1_req;
  end

  // Direction of the transaction currently owned; requesters keep it stable
  // while granted, so it is safe to read it throughout ACCESS.
  always_comb begin
    owner_we = owner ? m1_we : m0_we;
  end

  // Next-state logic: grant in IDLE, wait/timeout in ACCESS, one DONE cycle.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    grant_take    = 1'b0;
    capture       = 1'b0;
    capture_rdata = '0;
    capture_err   = 1'b0;
    unique case (state)
      IDLE: begin
        wait_cnt_next = 8'd0;
        if (any_req) begin
          grant_take = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // A ready on the timeout cycle still counts as success, so the
        // ready check must take priority over the timeout check.
        if (mem_ready) begin
          capture       = 1'b1;
          capture_rdata = owner_we ? '0 : mem_rdata;
          capture_err   = 1'b0;
          state_next    = DONE;
        end else if (wait_cnt == TIMEOUT_C) begin
          capture       = 1'b1;
          capture_rdata = '0;
          capture_err   = 1'b1;
          state_next    = DONE;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      DONE: begin
        // Requests seen during DONE are not granted here; a request still
        // high in the following IDLE cycle is arbitrated as a new one.
        wait_cnt_next = 8'd0;
        state_next    = IDLE;
      end
      default: begin
        wait_cnt_next = 8'd0;
        state_next    = IDLE;
      end
    endcase
  end

  // State and wait counter registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Owner tracking; last_owner starts at 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else if (grant_take) begin
      owner      <= winner;
      last_owner <= winner;
    end
  end

  // Per-port result registers; only the owner's pair is updated, the other
  // port keeps showing the result of its own last transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
    end else if (capture) begin
      if (owner) begin
        m1_rdata <= capture_rdata;
        m1_err   <= capture_err;
      end else begin
        m0_rdata <= capture_rdata;
        m0_err   <= capture_err;
      end
    end
  end

  // Output decode from registered state and owner only; no req reaches
  // gnt/mem_en combinationally.
  always_comb begin
    busy    = (state != IDLE);
    m0_gnt  = busy & ~owner;
    m1_gnt  = busy &  owner;
    m0_done = (state == DONE) & ~owner;
    m1_done = (state == DONE) &  owner;
    mem_en  = (state == ACCESS);
    mem_we  = (state == ACCESS) & owner_we;
  end

  // Address and write data follow the owner's request lines.
  always_comb begin
    mem_adr   = owner ? m1_adr   : m0_adr;
    mem_wdata = owner ? m1_wdata : m0_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter. A transaction-level model
//            predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations (latency, data, grant order).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    we  = '0;
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wd  [2];
  logic          m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we, busy, owner;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_adr(adr[0]), .m0_wdata(wd[0]),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(req[1]), .m1_we(we[1]), .m1_adr(adr[1]), .m1_wdata(wd[1]),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // stalled: number of not-ready ACCESS cycles of the open transaction,
  // -1 when no transaction is open; fin marks the completion cycle.
  int            stalled = -1;
  bit            fin = 1'b0;
  bit            m_own = 1'b0;
  bit            m_last = 1'b1;
  logic [DW-1:0] m_rd [2] = '{default: '0};
  bit            m_er [2] = '{default: 1'b0};

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      stalled = -1; fin = 0; m_own = 0; m_last = 1;
      m_rd[0] = '0; m_rd[1] = '0; m_er[0] = 0; m_er[1] = 0;
    end else if (fin) begin
      fin = 0;
    end else if (stalled >= 0) begin
      if (mem_ready) begin
        m_rd[m_own] = we[m_own] ? '0 : mem_rdata;
        m_er[m_own] = 0;
        fin = 1; stalled = -1;
      end else if (stalled == TO) begin
        m_rd[m_own] = '0;
        m_er[m_own] = 1;
        fin = 1; stalled = -1;
      end else begin
        stalled = stalled + 1;
      end
    end else if (req[0] || req[1]) begin
      m_own   = (req[0] && req[1]) ? !m_last : req[1];
      m_last  = m_own;
      stalled = 0;
    end
  end

  // Compare process: every output, every cycle, away from the clock edge.
  initial forever begin
    bit act, bz;
    @(negedge clk);
    act = (stalled >= 0);
    bz  = act || fin;
    check("gnt0",   m0_gnt,   bz && !m_own);
    check("gnt1",   m1_gnt,   bz &&  m_own);
    check("done0",  m0_done,  fin && !m_own);
    check("done1",  m1_done,  fin &&  m_own);
    check("rdata0", m0_rdata, m_rd[0]);
    check("rdata1", m1_rdata, m_rd[1]);
    check("err0",   m0_err,   m_er[0]);
    check("err1",   m1_err,   m_er[1]);
    check("mem_en", mem_en,   act);
    check("mem_we", mem_we,   act && we[m_own]);
    check("busy",   busy,     bz);
    check("owner",  owner,    m_own);
    check("gnt_overlap", m0_gnt & m1_gnt, 1'b0);
    if (act) begin
      check("mem_adr",   mem_adr,   adr[m_own]);
      check("mem_wdata", mem_wdata, wd[m_own]);
    end
  end

  // ---------------- memory responder ----------------
  // lat: ACCESS cycle (1-based) on which ready is given; 0 = never.
  // stray: drive ready while no access is open (must be ignored).
  int            lat = 1;
  bit            stray = 0;
  logic [DW-1:0] rdv = '0;
  int            acc_seen = 0;

  initial forever begin
    @(negedge clk);
    if (mem_en) acc_seen++; else acc_seen = 0;
    mem_ready = mem_en ? (lat != 0 && acc_seen == lat) : stray;
    mem_rdata = rdv;
  end

  // ---------------- grant / done monitor ----------------
  int glog [$];
  int done0_cnt = 0, done1_cnt = 0;
  bit pg0 = 0, pg1 = 0;

  initial forever begin
    @(negedge clk);
    if (m0_gnt && !pg0) glog.push_back(0);
    if (m1_gnt && !pg1) glog.push_back(1);
    pg0 = m0_gnt; pg1 = m1_gnt;
    if (m0_done) done0_cnt++;
    if (m1_done) done1_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic gnt_of(input int p);
    return (p != 0) ? m1_gnt : m0_gnt;
  endfunction
  function automatic logic done_of(input int p);
    return (p != 0) ? m1_done : m0_done;
  endfunction

  task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w; adr[p] = a; wd[p] = d;
  endtask

  task automatic release_req(input int p);
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  // Waits (bounded) for the port's done pulse; cyc counts negedges since issue.
  task automatic wait_done(input int p, input bit drop_early, output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (done_of(p)) seen = 1;
      else if (drop_early && gnt_of(p) && req[p]) begin
        @(posedge clk); #1;
        req[p] = 1'b0;
      end
    end
    check($sformatf("done_wait_p%0d", p), seen, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    int exp_order [6];
    adr[0] = '0; adr[1] = '0; wd[0] = '0; wd[1] = '0;

    // Reset state
    @(negedge clk);
    check("rst_owner", owner, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_mem_en", mem_en, 1'b0);

    // Both ports issue 3 back-to-back writes from the first cycle after reset
    @(posedge clk); #1;
    glog.delete();
    lat = 1;
    we = 2'b11;
    adr[0] = 32'h1000; wd[0] = 32'hA000_0000;
    adr[1] = 32'h1100; wd[1] = 32'hB000_0000;
    req = 2'b11;
    reset = 1'b0;
    fork
      for (int k = 0; k < 3; k++) begin
        int c0;
        wait_done(0, 0, c0);
        @(posedge clk); #1;
        if (k < 2) begin adr[0] = 32'h1000 + 32'(4*(k+1)); wd[0] = 32'hA000_0000 + 32'(k+1); end
        else req[0] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        int c1;
        wait_done(1, 0, c1);
        @(posedge clk); #1;
        if (k < 2) begin adr[1] = 32'h1100 + 32'(4*(k+1)); wd[1] = 32'hB000_0000 + 32'(k+1); end
        else req[1] = 1'b0;
      end
    join
    exp_order = '{0, 1, 0, 1, 0, 1};
    check("order_len", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      check($sformatf("order_%0d", i), glog[i], exp_order[i]);

    // Port 0 read of 0x100, ready on 2nd ACCESS cycle
    lat = 2; rdv = 32'hDEADBEEF;
    issue(0, 1'b0, 32'h100, 32'h0);
    wait_done(0, 0, cyc);
    check("rd0_latency", cyc, 4);
    check("rd0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd0_err",   m0_err,   1'b0);
    release_req(0);

    // Port 1 write: returns rdata 0 even though memory drives data
    lat = 3; rdv = 32'hCAFEF00D;
    issue(1, 1'b1, 32'h180, 32'h5555AAAA);
    wait_done(1, 0, cyc);
    check("wr1_latency", cyc, 5);
    check("wr1_rdata", m1_rdata, 32'h0);
    check("rd0_hold",  m0_rdata, 32'hDEADBEEF);
    release_req(1);

    // Port 1 read, memory never ready -> timeout
    lat = 0; rdv = 32'h11112222;
    issue(1, 1'b0, 32'h200, 32'h0);
    wait_done(1, 0, cyc);
    check("to_latency", cyc, TO + 3);
    check("to_err",   m1_err,   1'b1);
    check("to_rdata", m1_rdata, 32'h0);
    release_req(1);
    @(negedge clk);
    check("to_idle", busy, 1'b0);

    // Ready exactly when the counter equals TIMEOUT -> success
    lat = TO + 1; rdv = 32'h12345678;
    issue(1, 1'b0, 32'h204, 32'h0);
    wait_done(1, 0, cyc);
    check("edge_latency", cyc, TO + 3);
    check("edge_err",   m1_err,   1'b0);
    check("edge_rdata", m1_rdata, 32'h12345678);
    release_req(1);

    // Reset mid-ACCESS for port 1, then a tie goes to port 0
    lat = 0;
    issue(1, 1'b0, 32'h300, 32'h0);
    done1_cnt = 0;
    repeat (4) @(negedge clk);
    check("pre_rst_gnt1", m1_gnt, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_now_gnt1",  m1_gnt, 1'b0);
    check("rst_now_mem_en", mem_en, 1'b0);
    @(negedge clk);
    check("rst_rdata1", m1_rdata, 32'h0);
    @(posedge clk); #1;
    glog.delete();
    lat = 1; rdv = 32'h0BAD_F00D;
    adr[0] = 32'h310; we[0] = 1'b0;
    req[0] = 1'b1;
    reset = 1'b0;
    check("rst_no_done1", done1_cnt, 0);
    fork
      begin int c0; wait_done(0, 0, c0); release_req(0); end
      begin int c1; wait_done(1, 0, c1); release_req(1); end
    join
    check("tie_after_rst", glog.size() > 0 ? glog[0] : -1, 0);

    // Port 0 drops req during ACCESS; stray ready outside ACCESS
    @(posedge clk); #1;
    glog.delete();
    done0_cnt = 0;
    stray = 1; lat = 3; rdv = 32'h0000A5A5;
    issue(0, 1'b0, 32'h400, 32'h0);
    wait_done(0, 1, cyc);
    check("drop_latency", cyc, 5);
    repeat (6) @(negedge clk);
    check("drop_done_cnt", done0_cnt, 1);
    check("drop_grants",   glog.size(), 1);
    check("drop_rdata",    m0_rdata, 32'h0000A5A5);
    stray = 0;

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
